// File: rtl/hazard_stall_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_stall_ctrl
//
// Central hazard and pipeline-sequencing controller for the 5-stage CPU.
// Detects load-use hazards in ID, taken branches resolved in MEM and data-memory
// wait states, and drives the pipeline register enables, flushes and the ID/EX
// bubble-select. A two-state FSM (RUN / MEM_WAIT) tracks outstanding data-memory
// accesses with a wait timeout. Saturating counters record stall and flush cycles.
//
// Ports:
//   clk, rst            clock (rising edge), synchronous active-high reset
//   id_rs1/id_rs2       source register indices of the instruction in ID
//   id_use_rs1/rs2      ID instruction actually reads rs1 / rs2
//   ex_memread, ex_rd   instruction in EX is a load, and its destination
//   mem_branch_taken    branch in MEM resolved taken
//   mem_req, mem_ack    MEM-stage data access request / completion
//   pc_write            PC load enable
//   if_id_write/flush   IF/ID write enable / clear to NOP
//   ctrl_select         1 = decoded controls into ID/EX, 0 = bubble
//   id_ex_write         ID/EX write enable
//   ex_mem_write/flush  EX/MEM write enable / clear controls
//   mem_wb_bubble       write MEM/WB with zero controls
//   mem_err             sticky memory wait timeout flag
//   stall_cnt           saturating count of stall/freeze cycles
//   flush_cnt           saturating count of branch-flush cycles
//   dbg_state           current FSM state (0 = RUN, 1 = MEM_WAIT)
//
// Handshake: the data memory is a req/ack pair. An access is in flight from the
// first cycle mem_req is seen in RUN until the cycle mem_ack is high (that cycle
// completes it and is not frozen) or the wait budget runs out. While in
// MEM_WAIT, mem_req is not re-sampled: the MEM stage is frozen and holds it.
// -----------------------------------------------------------------------------
module hazard_stall_ctrl #(
  parameter int WAIT_MAX = 16,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             ex_memread,
  input  logic [4:0]       ex_rd,
  input  logic             mem_branch_taken,
  input  logic             mem_req,
  input  logic             mem_ack,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             ctrl_select,
  output logic             id_ex_write,
  output logic             ex_mem_write,
  output logic             ex_mem_flush,
  output logic             mem_wb_bubble,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             dbg_state
);

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_e;

  localparam logic [7:0]       WAIT_LAST = 8'(WAIT_MAX - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  state_e           state_q, state_d;
  logic [7:0]       wait_cnt_q, wait_cnt_d;
  logic             mem_err_q, mem_err_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic lu;
  logic fz;
  logic timeout;
  logic in_wait;

  // Hazard classification
  always_comb begin
    in_wait = (state_q == MEM_WAIT);
    lu      = ex_memread && (ex_rd != 5'd0) &&
              ((id_use_rs1 && (id_rs1 == ex_rd)) ||
               (id_use_rs2 && (id_rs2 == ex_rd)));
    fz      = (!in_wait && mem_req && !mem_ack) ||
              (in_wait && !mem_ack && (wait_cnt_q < WAIT_LAST));
    // ">=" rather than "==" so a budget of one cycle still times out.
    timeout = in_wait && !mem_ack && !(wait_cnt_q < WAIT_LAST);
  end

  // Pipeline control outputs, highest priority first
  always_comb begin
    pc_write      = 1'b1;
    if_id_write   = 1'b1;
    if_id_flush   = 1'b0;
    ctrl_select   = 1'b1;
    id_ex_write   = 1'b1;
    ex_mem_write  = 1'b1;
    ex_mem_flush  = 1'b0;
    mem_wb_bubble = 1'b0;

    if (fz) begin
      // Whole pipeline holds; MEM/WB receives a bubble so WB does not repeat.
      pc_write      = 1'b0;
      if_id_write   = 1'b0;
      id_ex_write   = 1'b0;
      ex_mem_write  = 1'b0;
      mem_wb_bubble = 1'b1;
    end else if (mem_branch_taken) begin
      if_id_flush  = 1'b1;
      ctrl_select  = 1'b0;
      ex_mem_flush = 1'b1;
    end else if (lu) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      ctrl_select = 1'b0;
    end

    // A timed-out access is dropped: pipeline advances but MEM/WB gets nothing.
    if (timeout) begin
      mem_wb_bubble = 1'b1;
    end

    if (rst) begin
      pc_write      = 1'b0;
      if_id_write   = 1'b0;
      if_id_flush   = 1'b1;
      ctrl_select   = 1'b0;
      id_ex_write   = 1'b1;
      ex_mem_write  = 1'b1;
      ex_mem_flush  = 1'b1;
      mem_wb_bubble = 1'b1;
    end
  end

  // FSM next state and counters
  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    mem_err_d   = mem_err_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;

    case (state_q)
      RUN: begin
        if (mem_req && !mem_ack) begin
          state_d    = MEM_WAIT;
          wait_cnt_d = 8'd1;
        end
      end
      MEM_WAIT: begin
        if (mem_ack || timeout) begin
          state_d    = RUN;
          wait_cnt_d = 8'd0;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      default: begin
        state_d    = RUN;
        wait_cnt_d = 8'd0;
      end
    endcase

    if (timeout) begin
      mem_err_d = 1'b1;
    end

    if ((fz || (lu && !mem_branch_taken)) && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
    if (!fz && mem_branch_taken && (flush_cnt_q != CNT_MAX)) begin
      flush_cnt_d = flush_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      wait_cnt_q  <= 8'd0;
      mem_err_q   <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      mem_err_q   <= mem_err_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign mem_err   = mem_err_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_stall_ctrl
//
// Bench for hazard_stall_ctrl. Two instances share the stimulus: one with 8-bit
// counters and one with 2-bit counters for saturation. Both use WAIT_MAX=4.
// Outputs are packed as {pc_write, if_id_write, if_id_flush, ctrl_select,
// id_ex_write, ex_mem_write, ex_mem_flush, mem_wb_bubble}.
// -----------------------------------------------------------------------------
module tb_hazard_stall_ctrl;

  localparam int WAIT_MAX = 4;
  localparam int CW_A     = 8;
  localparam int CW_B     = 2;

  localparam logic [7:0] O_RST  = 8'b0010_1111;
  localparam logic [7:0] O_RUN  = 8'b1101_1100;
  localparam logic [7:0] O_LU   = 8'b0000_1100;
  localparam logic [7:0] O_BR   = 8'b1110_1110;
  localparam logic [7:0] O_FZ   = 8'b0001_0001;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_use_rs1, id_use_rs2, ex_memread, mem_branch_taken, mem_req, mem_ack;

  logic            pc_write, if_id_write, if_id_flush, ctrl_select;
  logic            id_ex_write, ex_mem_write, ex_mem_flush, mem_wb_bubble, mem_err;
  logic [CW_A-1:0] stall_cnt, flush_cnt;
  logic            dbg_state;

  logic            b_pc_write, b_if_id_write, b_if_id_flush, b_ctrl_select;
  logic            b_id_ex_write, b_ex_mem_write, b_ex_mem_flush, b_mem_wb_bubble, b_mem_err;
  logic [CW_B-1:0] b_stall_cnt, b_flush_cnt;
  logic            b_dbg_state;

  hazard_stall_ctrl #(.WAIT_MAX(WAIT_MAX), .CNT_W(CW_A)) dut (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_memread(ex_memread),
    .ex_rd(ex_rd), .mem_branch_taken(mem_branch_taken), .mem_req(mem_req),
    .mem_ack(mem_ack), .pc_write(pc_write), .if_id_write(if_id_write),
    .if_id_flush(if_id_flush), .ctrl_select(ctrl_select), .id_ex_write(id_ex_write),
    .ex_mem_write(ex_mem_write), .ex_mem_flush(ex_mem_flush),
    .mem_wb_bubble(mem_wb_bubble), .mem_err(mem_err), .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt), .dbg_state(dbg_state)
  );

  hazard_stall_ctrl #(.WAIT_MAX(WAIT_MAX), .CNT_W(CW_B)) dut_sat (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_memread(ex_memread),
    .ex_rd(ex_rd), .mem_branch_taken(mem_branch_taken), .mem_req(mem_req),
    .mem_ack(mem_ack), .pc_write(b_pc_write), .if_id_write(b_if_id_write),
    .if_id_flush(b_if_id_flush), .ctrl_select(b_ctrl_select), .id_ex_write(b_id_ex_write),
    .ex_mem_write(b_ex_mem_write), .ex_mem_flush(b_ex_mem_flush),
    .mem_wb_bubble(b_mem_wb_bubble), .mem_err(b_mem_err), .stall_cnt(b_stall_cnt),
    .flush_cnt(b_flush_cnt), .dbg_state(b_dbg_state)
  );

  wire [7:0] outs = {pc_write, if_id_write, if_id_flush, ctrl_select,
                     id_ex_write, ex_mem_write, ex_mem_flush, mem_wb_bubble};

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // pend = cycles the current access has gone unacknowledged (0 = none in flight)
  int pend    = 0;
  bit m_err   = 1'b0;
  int m_stall = 0;
  int m_flush = 0;

  function automatic int sat(input int v, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  function automatic bit m_lu();
    return ex_memread && ex_rd != 0 &&
           ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
  endfunction

  function automatic bit m_fz();
    if (mem_ack) return 1'b0;
    if (pend == 0) return mem_req;
    return pend + 1 < WAIT_MAX;
  endfunction

  function automatic bit m_tmo();
    return pend != 0 && !mem_ack && pend + 1 >= WAIT_MAX;
  endfunction

  function automatic logic [7:0] m_out();
    logic [7:0] o;
    if (rst) return O_RST;
    if (m_fz()) o = O_FZ;
    else if (mem_branch_taken) o = O_BR;
    else if (m_lu()) o = O_LU;
    else o = O_RUN;
    if (m_tmo()) o[0] = 1'b1;
    return o;
  endfunction

  // ---------------- driver ----------------
  task automatic set_in(input bit a_rst, input int a_rs1, input int a_rs2,
                        input bit a_u1, input bit a_u2, input bit a_mr, input int a_rd,
                        input bit a_br, input bit a_req, input bit a_ack);
    @(negedge clk);
    rst = a_rst; id_rs1 = 5'(a_rs1); id_rs2 = 5'(a_rs2);
    id_use_rs1 = a_u1; id_use_rs2 = a_u2; ex_memread = a_mr; ex_rd = 5'(a_rd);
    mem_branch_taken = a_br; mem_req = a_req; mem_ack = a_ack;
  endtask

  // One clock: check combinational outputs mid-cycle, advance model, check registers.
  task automatic tick();
    bit fz, lu, tmo;
    #2;
    chk("outputs", 32'(outs), 32'(m_out()));
    fz = m_fz(); lu = m_lu(); tmo = m_tmo();
    @(posedge clk);
    #1;
    if (rst) begin
      pend = 0; m_err = 1'b0; m_stall = 0; m_flush = 0;
    end else begin
      if (fz || (lu && !mem_branch_taken)) m_stall++;
      if (!fz && mem_branch_taken) m_flush++;
      if (tmo) m_err = 1'b1;
      pend = (fz) ? pend + 1 : 0;
    end
    chk("stall_cnt", 32'(stall_cnt), 32'(sat(m_stall, CW_A)));
    chk("flush_cnt", 32'(flush_cnt), 32'(sat(m_flush, CW_A)));
    chk("sat_stall_cnt", 32'(b_stall_cnt), 32'(sat(m_stall, CW_B)));
    chk("sat_flush_cnt", 32'(b_flush_cnt), 32'(sat(m_flush, CW_B)));
    chk("mem_err", 32'(mem_err), 32'(m_err));
    chk("state", 32'(dbg_state), 32'(pend != 0));
  endtask

  task automatic idle();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
  endtask

  task automatic do_reset();
    set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit         rst, u1, u2, mr, br, req, ack;
    int         rs1, rs2, rd;
    logic [7:0] exp;
  } vec_t;

  function automatic vec_t mk(input bit r, input int rs1, input int rs2, input bit u1,
                              input bit u2, input bit mr, input int rd, input bit br,
                              input bit req, input bit ack, input logic [7:0] exp);
    vec_t v;
    v.rst = r; v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2; v.mr = mr;
    v.rd = rd; v.br = br; v.req = req; v.ack = ack; v.exp = exp;
    return v;
  endfunction

  vec_t tbl[12];

  initial begin
    // rows run back to back from a fresh reset; row 9 leaves MEM_WAIT for row 10
    tbl[0]  = mk(1, 5, 5, 1, 1, 1, 5, 1, 1, 0, O_RST);
    tbl[1]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_RUN);
    tbl[2]  = mk(0, 5, 0, 1, 0, 1, 5, 0, 0, 0, O_LU);
    tbl[3]  = mk(0, 0, 0, 1, 0, 1, 0, 0, 0, 0, O_RUN);
    tbl[4]  = mk(0, 1, 7, 1, 1, 1, 7, 0, 0, 0, O_LU);
    tbl[5]  = mk(0, 7, 0, 0, 0, 1, 7, 0, 0, 0, O_RUN);
    tbl[6]  = mk(0, 9, 0, 1, 0, 0, 9, 0, 0, 0, O_RUN);
    tbl[7]  = mk(0, 5, 0, 1, 0, 1, 5, 1, 0, 0, O_BR);
    tbl[8]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, O_RUN);
    tbl[9]  = mk(0, 3, 0, 1, 0, 1, 3, 1, 1, 0, O_FZ);
    tbl[10] = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 1, O_BR);
    tbl[11] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_RUN);

    set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);

    // ---- table ----
    for (int i = 0; i < 12; i++) begin
      set_in(tbl[i].rst, tbl[i].rs1, tbl[i].rs2, tbl[i].u1, tbl[i].u2, tbl[i].mr,
             tbl[i].rd, tbl[i].br, tbl[i].req, tbl[i].ack);
      #2;
      chk($sformatf("table_%0d", i), 32'(outs), 32'(tbl[i].exp));
      tick();
    end

    // ---- load-use, then ex_rd=0 ----
    do_reset();
    set_in(0, 5, 0, 1, 0, 1, 5, 0, 0, 0); tick();
    chk("lu_stall_cnt", 32'(stall_cnt), 32'd1);
    set_in(0, 0, 0, 1, 0, 1, 0, 0, 0, 0); tick();
    chk("lu_rd0_stall_cnt", 32'(stall_cnt), 32'd1);

    // ---- branch + load-use ----
    set_in(0, 5, 0, 1, 0, 1, 5, 1, 0, 0);
    #2 chk("br_lu_out", 32'(outs), 32'(O_BR));
    tick();
    chk("br_lu_flush_cnt", 32'(flush_cnt), 32'd1);
    chk("br_lu_stall_cnt", 32'(stall_cnt), 32'd1);

    // ---- memory wait, ack on 4th cycle ----
    do_reset();
    for (int i = 0; i < 3; i++) begin
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      #2 chk($sformatf("wait_fz_%0d", i), 32'(outs), 32'(O_FZ));
      tick();
    end
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    #2 chk("wait_ack_out", 32'(outs), 32'(O_RUN));
    tick();
    chk("wait_stall_cnt", 32'(stall_cnt), 32'd3);
    chk("wait_state_run", 32'(dbg_state), 32'd0);

    // ---- zero-wait access ----
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 1); tick();
    chk("zero_wait_stall_cnt", 32'(stall_cnt), 32'd3);

    // ---- timeout ----
    do_reset();
    for (int i = 0; i < 3; i++) begin
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      #2 chk($sformatf("tmo_fz_%0d", i), 32'(outs), 32'(O_FZ));
      tick();
    end
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    #2 chk("tmo_release_out", 32'(outs), 32'(O_RUN | 8'h01));
    tick();
    chk("tmo_mem_err", 32'(mem_err), 32'd1);
    chk("tmo_state_run", 32'(dbg_state), 32'd0);
    for (int i = 0; i < 3; i++) idle();
    chk("tmo_mem_err_sticky", 32'(mem_err), 32'd1);
    do_reset();
    chk("tmo_mem_err_cleared", 32'(mem_err), 32'd0);

    // ---- reset mid-wait ----
    set_in(0, 0, 0, 0, 0, 0, 0, 1, 1, 0); tick();
    set_in(1, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    #2 chk("rst_mid_out", 32'(outs), 32'(O_RST));
    tick();
    chk("rst_mid_state", 32'(dbg_state), 32'd0);
    chk("rst_mid_stall", 32'(stall_cnt), 32'd0);
    chk("rst_mid_flush", 32'(flush_cnt), 32'd0);
    chk("rst_mid_err", 32'(mem_err), 32'd0);
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2 chk("rst_mid_no_freeze", 32'(outs), 32'(O_RUN));
    tick();

    // ---- saturation on 2-bit counters ----
    do_reset();
    for (int i = 0; i < 5; i++) begin
      set_in(0, 4, 0, 1, 0, 1, 4, 0, 0, 0); tick();
    end
    chk("sat_stall_3", 32'(b_stall_cnt), 32'd3);
    chk("sat_stall_wide_5", 32'(stall_cnt), 32'd5);

    // ---- randomized against the model ----
    do_reset();
    for (int i = 0; i < 600; i++) begin
      set_in($urandom_range(0, 49) == 0,
             $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
             $urandom_range(0, 1) == 1, $urandom_range(0, 3),
             $urandom_range(0, 5) == 0, $urandom_range(0, 2) == 0,
             $urandom_range(0, 3) == 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute time bound in case the stimulus process stalls.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach its end, expected completion");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Central hazard and pipeline-sequencing controller for the 5-stage pipelined CPU.
- Detects load-use hazards in ID, taken branches resolved in MEM, and data-memory wait states.
- Drives the ID/EX bubble-select input of the control mux (ctrl_select), plus PC/IF-ID/EX-MEM write enables and flushes.
- Keeps a memory-wait FSM, a wait timeout and saturating performance counters.

Parameters:
WAIT_MAX, 16, max consecutive MEM_WAIT cycles without ack before timeout (range 1..255)
CNT_W, 32, width of stall_cnt and flush_cnt

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous active-high reset
id_rs1  in  5  rs1 index of instruction in ID
id_rs2  in  5  rs2 index of instruction in ID
id_use_rs1  in  1  ID instruction reads rs1
id_use_rs2  in  1  ID instruction reads rs2
ex_memread  in  1  ID/EX MemRead (instruction in EX is a load)
ex_rd  in  5  ID/EX destination register
mem_branch_taken  in  1  branch in MEM resolved taken
mem_req  in  1  MEM-stage instruction accesses data memory this cycle
mem_ack  in  1  data memory completes access this cycle
pc_write  out  1  PC register load enable
if_id_write  out  1  IF/ID register write enable
if_id_flush  out  1  clear IF/ID to NOP
ctrl_select  out  1  1 = pass decoded controls into ID/EX, 0 = inject bubble
id_ex_write  out  1  ID/EX write enable
ex_mem_write  out  1  EX/MEM write enable
ex_mem_flush  out  1  clear EX/MEM controls
mem_wb_bubble  out  1  write MEM/WB with zero controls
mem_err  out  1  sticky: memory wait timeout occurred
stall_cnt  out  CNT_W  saturating count of stall/freeze cycles
flush_cnt  out  CNT_W  saturating count of branch-flush cycles

Behaviour:
- Single clock domain, synchronous active-high reset on clk rising edge.
- State: RUN, MEM_WAIT. Registered: state, wait_cnt (8 bit), mem_err, stall_cnt, flush_cnt.
- Reset: state=RUN, wait_cnt=0, mem_err=0, counters=0.
- While rst=1, combinational outputs are: pc_write=0, if_id_write=0, if_id_flush=1, ctrl_select=0, id_ex_write=1, ex_mem_write=1, ex_mem_flush=1, mem_wb_bubble=1.
- Load-use hazard (lu) = ex_memread & ex_rd!=0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
- Freeze (fz) = (RUN & mem_req & !mem_ack) | (MEM_WAIT & !mem_ack & wait_cnt<WAIT_MAX-1).
- Output priority, all same-cycle combinational, no added latency:
  - fz: all four write enables = 0, mem_wb_bubble=1, ctrl_select=1, both flushes=0.
  - else mem_branch_taken: pc_write=1, if_id_write=1, if_id_flush=1, ctrl_select=0, ex_mem_flush=1, id_ex_write=1, ex_mem_write=1, mem_wb_bubble=0.
  - else lu: pc_write=0, if_id_write=0, ctrl_select=0, id_ex_write=1, ex_mem_write=1, flushes=0, mem_wb_bubble=0.
  - else normal run: all write enables=1, ctrl_select=1, flushes=0, mem_wb_bubble=0.
- Simultaneous branch and lu: branch wins; no stall counted.
- mem_branch_taken while fz: ignored that cycle; it is acted on when the freeze releases (the MEM stage holds it).
- FSM transitions:
  - RUN: mem_req & !mem_ack -> MEM_WAIT, wait_cnt=1. mem_req & mem_ack in the same cycle -> stay RUN, no stall.
  - MEM_WAIT & mem_ack -> RUN, wait_cnt=0. That cycle is unfrozen and the pipeline advances.
  - MEM_WAIT & !mem_ack & wait_cnt<WAIT_MAX-1 -> wait_cnt+1.
  - MEM_WAIT & !mem_ack & wait_cnt==WAIT_MAX-1 -> timeout: mem_err<=1, RUN, wait_cnt=0. That cycle is unfrozen with mem_wb_bubble=1, so the access is dropped.
- mem_err clears only on rst.
- Counters:
  - stall_cnt +1 on every cycle with fz or (lu & !mem_branch_taken).
  - flush_cnt +1 on every unfrozen mem_branch_taken cycle.
  - Both saturate at all-ones and never increment during rst.
- Reset mid-MEM_WAIT: next cycle is RUN, with no residual freeze.

Test Plan:
- Load-use: ex_memread=1, ex_rd=5, id_rs1=5, id_use_rs1=1 for 1 cycle -> pc_write=0, if_id_write=0, ctrl_select=0 that cycle; stall_cnt=1. Repeat with ex_rd=0 -> no stall.
- Branch+lu: mem_branch_taken=1 with lu active -> if_id_flush=1, ex_mem_flush=1, ctrl_select=0, pc_write=1; flush_cnt=1, stall_cnt unchanged.
- Mem wait: mem_req=1, ack after 3 cycles -> freeze for 3 cycles (writes=0, mem_wb_bubble=1), ack cycle unfrozen; stall_cnt=3, state RUN.
- Zero-wait: mem_req=1, mem_ack=1 same cycle -> no freeze, stall_cnt unchanged.
- Timeout, WAIT_MAX=4, no ack -> 3 frozen cycles, 4th cycle unfrozen with mem_wb_bubble=1; mem_err=1 persists until rst.
- Reset mid-wait (rst in cycle 2 of MEM_WAIT) -> during rst ctrl_select=0, if_id_flush=1; after rst RUN, counters=0, mem_err=0. Counter saturation with CNT_W=2: 5 stalls -> stall_cnt=3.
